// File: rtl/eviction_write_buffer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : eviction_write_buffer_multi
//  Brief    : DEPTH-entry FIFO that absorbs dirty-line evictions from L1,
//             coalesces repeat evictions of a buffered line, forwards
//             buffered data to refills and drains to pmem in FIFO order,
//             yielding to pending pmem reads.
//  Revision : 1.0 - initial release
// ============================================================================
module eviction_write_buffer_multi #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evict_write,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic              evict_ready,
    input  logic              pmem_read,
    input  logic [ADDR_W-1:0] read_addr,
    output logic              read_hit,
    output logic [LINE_W-1:0] read_data,
    input  logic              pmem_resp,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] c_PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WB   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [LINE_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_ev_match;
    logic [PTR_W-1:0]  w_ev_idx;
    logic              w_head_busy;
    logic              w_accept;
    logic              w_push;
    logic              w_coal;
    logic              w_pop;

    assign full  = (r_count == c_CNT_FULL);
    assign empty = (r_count == '0);

    // Look up the incoming eviction address among valid entries (at most one can match)
    always_comb begin
        w_ev_match = 1'b0;
        w_ev_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == evict_addr)) begin
                w_ev_match = 1'b1;
                w_ev_idx   = PTR_W'(i);
            end
        end
    end

    // Forward buffered data to a pending refill; zero when nothing matches
    always_comb begin
        read_hit  = 1'b0;
        read_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == read_addr)) begin
                read_hit  = 1'b1;
                read_data = r_data[i];
            end
        end
    end

    // The head entry is frozen while it is being written to pmem, so a
    // coalesce onto it must stall rather than change data under the write.
    assign w_head_busy = (r_state == S_WB) && w_ev_match && (w_ev_idx == r_head);
    assign evict_ready = (!full || w_ev_match) && !w_head_busy;
    assign w_accept    = evict_write && evict_ready;
    assign w_push      = w_accept && !w_ev_match;
    assign w_coal      = w_accept && w_ev_match;
    assign w_pop       = (r_state == S_WB) && pmem_resp;

    assign pmem_address = empty ? '0 : r_addr[r_head];
    assign pmem_wdata   = empty ? '0 : r_data[r_head];

    // Next-state and Moore output: write only from S_WB, reads preempt a write
    always_comb begin
        w_state_nxt = r_state;
        pmem_write  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!empty && !pmem_read) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                pmem_write = 1'b1;
                if (pmem_resp || pmem_read) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, pointers, occupancy and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload: new lines land at the tail, repeats overwrite in place
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= evict_addr;
            r_data[r_tail] <= evict_data;
        end
        if (w_coal) begin
            r_data[w_ev_idx] <= evict_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eviction_write_buffer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eviction_write_buffer_multi
//  Brief    : Directed and random stimulus for eviction_write_buffer_multi,
//             compared every cycle against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eviction_write_buffer_multi;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int LW    = 128;

    localparam logic [LW-1:0] c_D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [LW-1:0] c_D2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [LW-1:0] c_D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0000;
    localparam logic [LW-1:0] c_D5 = 128'h5555_5555_0000_0000_5555_5555_0000_0000;
    localparam logic [LW-1:0] c_D6 = 128'h6666_0000_0000_6666_6666_0000_0000_6666;
    localparam logic [LW-1:0] c_D9 = 128'h9999_8888_7777_6666_5555_4444_3333_2222;

    logic          clk = 1'b0;
    logic          rst;
    logic          evict_write;
    logic [AW-1:0] evict_addr;
    logic [LW-1:0] evict_data;
    logic          evict_ready;
    logic          pmem_read;
    logic [AW-1:0] read_addr;
    logic          read_hit;
    logic [LW-1:0] read_data;
    logic          pmem_resp;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_wb;

    always #5 clk = ~clk;

    eviction_write_buffer_multi #(
        .DEPTH (DEPTH),
        .ADDR_W(AW),
        .LINE_W(LW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .evict_write (evict_write),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .evict_ready (evict_ready),
        .pmem_read   (pmem_read),
        .read_addr   (read_addr),
        .read_hit    (read_hit),
        .read_data   (read_data),
        .pmem_resp   (pmem_resp),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .full        (full),
        .empty       (empty)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int mfind(input logic [AW-1:0] a);
        foreach (mq[i]) begin
            if (mq[i].a == a) return i;
        end
        return -1;
    endfunction

    // Let combinational outputs settle, then compare all of them to the model
    task automatic settle();
        int ei;
        int ri;
        bit e_rdy;
        #1;
        ei    = mfind(evict_addr);
        ri    = mfind(read_addr);
        e_rdy = ((mq.size() < DEPTH) || (ei >= 0)) && !(m_wb && ei == 0);
        chk("evict_ready", evict_ready, e_rdy);
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("pmem_write", pmem_write, m_wb);
        chk("pmem_address", pmem_address, (mq.size() == 0) ? '0 : mq[0].a);
        chk("pmem_wdata", pmem_wdata, (mq.size() == 0) ? '0 : mq[0].d);
        chk("read_hit", read_hit, ri >= 0);
        chk("read_data", read_data, (ri >= 0) ? mq[ri].d : '0);
    endtask

    // Advance one clock and apply the same transaction to the model
    task automatic clock();
        int  idx;
        bit  acc;
        bit  nwb;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_wb = 1'b0;
        end else begin
            idx = mfind(evict_addr);
            acc = evict_write && ((mq.size() < DEPTH) || (idx >= 0)) && !(m_wb && idx == 0);
            if (!m_wb) nwb = (mq.size() > 0) && !pmem_read;
            else       nwb = !pmem_resp && !pmem_read;
            if (acc && idx >= 0) mq[idx].d = evict_data;
            if (m_wb && pmem_resp) void'(mq.pop_front());
            if (acc && idx < 0) mq.push_back('{evict_addr, evict_data});
            m_wb = nwb;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        clock();
    endtask

    task automatic set_idle();
        rst         = 1'b0;
        evict_write = 1'b0;
        evict_addr  = '0;
        evict_data  = '0;
        pmem_read   = 1'b0;
        read_addr   = '0;
        pmem_resp   = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
        evict_write = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        cycle();
        evict_write = 1'b0;
    endtask

    // Answer every write immediately until empty; n counts write cycles seen
    task automatic drain(output int n);
        bit done;
        n           = 0;
        done        = 1'b0;
        evict_write = 1'b0;
        pmem_read   = 1'b0;
        pmem_resp   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            settle();
            if (pmem_write) n++;
            if (empty && !pmem_write) begin
                done = 1'b1;
                break;
            end
            clock();
        end
        chk("drain_done", done, 1'b1);
        pmem_resp = 1'b0;
    endtask

    initial begin
        int n;
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        clock();
        rst = 1'b0;

        // Reset state and first push latency
        settle();
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_evict_ready", evict_ready, 1'b1);
        chk("rst_read_hit", read_hit, 1'b0);
        clock();
        evict_write = 1'b1; evict_addr = 16'h0010; evict_data = c_D0;
        settle();
        chk("t1_ready", evict_ready, 1'b1);
        clock();
        evict_write = 1'b0;
        settle();
        chk("t1_empty", empty, 1'b0);
        chk("t1_pw_early", pmem_write, 1'b0);
        clock();
        settle();
        chk("t1_pw", pmem_write, 1'b1);
        chk("t1_addr", pmem_address, 16'h0010);
        chk("t1_wdata", pmem_wdata, c_D0);
        clock();

        // Fill to full with no responses; a fifth distinct line is refused
        for (int i = 1; i < 4; i++) push(16'h0010 + AW'(i), {4{32'hA000_0000 + 32'(i)}});
        evict_write = 1'b1; evict_addr = 16'h0014; evict_data = c_D9;
        settle();
        chk("t2_full", full, 1'b1);
        chk("t2_ready", evict_ready, 1'b0);
        clock();
        evict_write = 1'b0; read_addr = 16'h0014;
        settle();
        chk("t2_still_full", full, 1'b1);
        chk("t2_dropped_hit", read_hit, 1'b0);
        clock();
        drain(n);
        chk("t2_drain_count", n, 4);

        // Coalesce onto a non-head entry, then forward it
        do_reset();
        pmem_read = 1'b1;
        push(16'h0030, c_D3);
        push(16'h0020, c_D2);
        evict_write = 1'b1; evict_addr = 16'h0020; evict_data = c_D9;
        settle();
        chk("t3_ready", evict_ready, 1'b1);
        clock();
        evict_write = 1'b0; read_addr = 16'h0020;
        settle();
        chk("t3_hit", read_hit, 1'b1);
        chk("t3_data", read_data, c_D9);
        clock();

        // Read aborts an in-flight write; head is retried afterwards
        pmem_read = 1'b0;
        cycle();
        settle();
        chk("t4_pw", pmem_write, 1'b1);
        chk("t4_addr", pmem_address, 16'h0030);
        pmem_read = 1'b1;
        settle();
        clock();
        pmem_read = 1'b0;
        settle();
        chk("t4_abort_pw", pmem_write, 1'b0);
        chk("t4_abort_addr", pmem_address, 16'h0030);
        clock();
        settle();
        chk("t4_retry_pw", pmem_write, 1'b1);
        chk("t4_retry_addr", pmem_address, 16'h0030);
        clock();
        drain(n);
        chk("t4_drain_count", n, 2);

        // Eviction of the line under write stalls until the response
        do_reset();
        push(16'h0030, c_D5);
        cycle();
        evict_write = 1'b1; evict_addr = 16'h0030; evict_data = c_D6;
        settle();
        chk("t5_stall0", evict_ready, 1'b0);
        clock();
        settle();
        chk("t5_stall1", evict_ready, 1'b0);
        pmem_resp = 1'b1;
        settle();
        chk("t5_stall_resp", evict_ready, 1'b0);
        clock();
        pmem_resp = 1'b0;
        settle();
        chk("t5_ready_after", evict_ready, 1'b1);
        chk("t5_empty_popped", empty, 1'b1);
        clock();
        evict_write = 1'b0;
        settle();
        chk("t5_empty_after", empty, 1'b0);
        clock();
        settle();
        chk("t5_pw", pmem_write, 1'b1);
        chk("t5_wdata", pmem_wdata, c_D6);
        clock();
        drain(n);
        chk("t5_drain_count", n, 1);

        // Reset during a write on a full buffer drops everything
        do_reset();
        for (int i = 0; i < 4; i++) push(16'h0040 + AW'(i), {4{32'hB000_0000 + 32'(i)}});
        settle();
        chk("t6_full", full, 1'b1);
        chk("t6_pw", pmem_write, 1'b1);
        rst = 1'b1;
        clock();
        rst = 1'b0;
        settle();
        chk("t6_rst_pw", pmem_write, 1'b0);
        chk("t6_rst_empty", empty, 1'b1);
        for (int i = 0; i < 4; i++) begin
            read_addr = 16'h0040 + AW'(i);
            settle();
            chk("t6_rst_hit", read_hit, 1'b0);
        end
        clock();

        // Random traffic over a small address pool to exercise coalescing
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            evict_write = ($urandom_range(0, 1) == 1);
            evict_addr  = 16'h0100 + AW'($urandom_range(0, 5));
            evict_data  = {$urandom, $urandom, $urandom, $urandom};
            pmem_read   = ($urandom_range(0, 3) == 0);
            pmem_resp   = ($urandom_range(0, 4) < 2);
            read_addr   = 16'h0100 + AW'($urandom_range(0, 6));
            cycle();
        end
        set_idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
